// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit producing HI/LO over WIDTH+1 cycles.
// Optional: define MULDIV_DIVZERO_EN to trap divide-by-zero via the div_zero port.
`timescale 1ns/1ps
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mf_req,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
`ifdef MULDIV_DIVZERO_EN
  ,output logic            div_zero
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
`ifdef MULDIV_DIVZERO_EN
  logic             dz_q, dz_d;
  logic             div_zero_q, div_zero_d;
`endif

  logic             sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   sum_mul, shifted, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    sgn   = ~op[0];
    abs_a = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
    abs_b = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;

    // Multiply: shift-add with multiplier in quo_q; divide: restoring step on {acc,quo}.
    sum_mul = {1'b0, acc_q} + (quo_q[0] ? {1'b0, den_q} : '0);
    shifted = {acc_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, den_q};

    prod     = {acc_q, quo_q};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -quo_q : quo_q;
    r_fix    = negr_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    den_d    = den_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_DIVZERO_EN
    dz_d       = dz_q;
    div_zero_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          acc_d    = '0;
          quo_d    = abs_a;
          den_d    = abs_b;
          is_div_d = op[1];
          neg_d    = sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          negr_d   = sgn & op_a[WIDTH-1];
          cnt_d    = CW'(WIDTH);
          state_d  = S_RUN;
`ifdef MULDIV_DIVZERO_EN
          dz_d = op[1] && (op_b == '0);
          if (op[1] && (op_b == '0)) state_d = S_FIX;
`endif
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (!diff[WIDTH]) begin
              acc_d = diff[WIDTH-1:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = shifted[WIDTH-1:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = sum_mul[WIDTH:1];
            quo_d = {sum_mul[0], quo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
`ifdef MULDIV_DIVZERO_EN
          if (dz_q) begin
            div_zero_d = 1'b1;
          end else
`endif
          if (is_div_q) begin
            hi_d = r_fix;
            lo_d = q_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      den_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      den_q    <= den_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULDIV_DIVZERO_EN
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign stall = busy & (start | mf_req);
`ifdef MULDIV_DIVZERO_EN
  assign div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (WIDTH=32).
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a, op_b;
  logic        mf_req, cancel;
  logic [31:0] hi, lo;
  logic        busy, done, stall;
`ifdef MULDIV_DIVZERO_EN
  logic        div_zero;
`endif

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .mf_req(mf_req), .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .stall(stall)
`ifdef MULDIV_DIVZERO_EN
    , .div_zero(div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output logic dn, output logic dn_after,
                        output logic dz);
    op = o; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    bcyc = 0;
    while (busy && bcyc < 200) begin
      bcyc++;
      tick();
    end
    dn = done;
`ifdef MULDIV_DIVZERO_EN
    dz = div_zero;
`else
    dz = 1'b0;
`endif
    tick();
    dn_after = done;
  endtask

  int   bc, n;
  logic dn, dna, dz;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
    mf_req = 1'b0; cancel = 1'b0;
    tick(); tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    mf_req = 1'b1; #1;
    chk("idle_mf_stall", 32'(stall), 32'd0);
    mf_req = 1'b0;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dn, dna, dz);
    chk("multu_busy_cycles", 32'(bc), 32'd33);
    chk("multu_done", 32'(dn), 32'd1);
    chk("multu_done_pulse", 32'(dna), 32'd0);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    run_op(2'b00, 32'hFFFFFFFD, 32'd7, bc, dn, dna, dz);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    run_op(2'b10, 32'hFFFFFFF9, 32'd2, bc, dn, dna, dz);
    chk("div_m7_2_lo", lo, 32'hFFFFFFFD);
    chk("div_m7_2_hi", hi, 32'hFFFFFFFF);

    run_op(2'b11, 32'd100, 32'd7, bc, dn, dna, dz);
    chk("divu_100_7_lo", lo, 32'd14);
    chk("divu_100_7_hi", hi, 32'd2);
    chk("divu_busy_cycles", 32'(bc), 32'd33);

    run_op(2'b10, 32'd7, 32'hFFFFFFFE, bc, dn, dna, dz);
    chk("div_7_m2_lo", lo, 32'hFFFFFFFD);
    chk("div_7_m2_hi", hi, 32'd1);

    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, bc, dn, dna, dz);
    chk("div_min_m1_lo", lo, 32'h80000000);
    chk("div_min_m1_hi", hi, 32'h0);

    // cancel and start together in IDLE: nothing accepted
    op = 2'b01; op_a = 32'd5; op_b = 32'd6; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_idle_busy", 32'(busy), 32'd0);

    op = 2'b01; op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("cancel_prebusy", 32'(busy), 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_done", 32'(done), 32'd0);
    chk("cancel_hi", hi, 32'h0);
    chk("cancel_lo", lo, 32'h80000000);
    tick();
    chk("cancel_done_later", 32'(done), 32'd0);

    run_op(2'b01, 32'd5, 32'd6, bc, dn, dna, dz);
    chk("after_cancel_lo", lo, 32'd30);
    chk("after_cancel_hi", hi, 32'd0);
    chk("after_cancel_done", 32'(dn), 32'd1);

    // stall while busy with start and mf_req held; operands change after acceptance
    mf_req = 1'b1;
    op = 2'b01; op_a = 32'h1234; op_b = 32'h10; start = 1'b1;
    tick();
    op_a = 32'd2; op_b = 32'd3;
    n = 0;
    while (busy && n < 200) begin
      chk("stall_busy", 32'(stall), 32'd1);
      n++;
      tick();
    end
    chk("stall_done_cycle", 32'(stall), 32'd0);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_busy_cycles", 32'(n), 32'd33);
    start = 1'b0;
    tick();
    mf_req = 1'b0;
    chk("held_start_one_op", 32'(busy), 32'd0);
    chk("held_start_lo", lo, 32'h00012340);
    chk("held_start_hi", hi, 32'h0);

    run_op(2'b11, 32'd9, 32'd0, bc, dn, dna, dz);
`ifdef MULDIV_DIVZERO_EN
    chk("divz_busy_cycles", 32'(bc), 32'd1);
    chk("divz_done", 32'(dn), 32'd1);
    chk("divz_flag", 32'(dz), 32'd1);
    chk("divz_hi", hi, 32'h0);
    chk("divz_lo", lo, 32'h00012340);
`else
    chk("divz_busy_cycles", 32'(bc), 32'd33);
    chk("divz_done", 32'(dn), 32'd1);
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_hi", hi, 32'd9);
    run_op(2'b10, 32'hFFFFFFF7, 32'd0, bc, dn, dna, dz);
    chk("sdivz_lo", lo, 32'h00000001);
    chk("sdivz_hi", hi, 32'hFFFFFFF7);
`endif

    run_op(2'b01, 32'd3, 32'd4, bc, dn, dna, dz);
    chk("pre_reset_lo", lo, 32'd12);
    op = 2'b01; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
